// File: rtl/serial_mag_comp_pkg.sv
// Shared encodings for the serial magnitude comparator: FSM states and the
// one-hot {g,e,l} result codes.
package serial_mag_comp_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [2:0] GEL_GT = 3'b100;
  localparam logic [2:0] GEL_EQ = 3'b010;
  localparam logic [2:0] GEL_LT = 3'b001;

  function automatic logic [2:0] gel_pack(input logic g, input logic e, input logic l);
    return {g, e, l};
  endfunction
endpackage

// File: rtl/serial_mag_comp_if.sv
// Request/result bundle of the serial magnitude comparator.
interface serial_mag_comp_if #(parameter int N = 8);
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic         g;
  logic         e;
  logic         l;

  modport master (output start, a, b, input  busy, done, g, e, l);
  modport slave  (input  start, a, b, output busy, done, g, e, l);
endinterface

// File: rtl/serial_mag_comp_1bit.sv
// Combinational 1-bit greater/equal/less cell.
module comp_1bit_gel (
  input  logic i_a,
  input  logic i_b,
  output logic o_g,
  output logic o_e,
  output logic o_l
);
  assign o_g = i_a & ~i_b;
  assign o_l = ~i_a & i_b;
  assign o_e = ~(i_a ^ i_b);
endmodule

// File: rtl/serial_mag_comp.sv
// MSB-first bit-serial magnitude comparator; one bit pair per clock through a
// single 1-bit g/e/l cell, optional early exit on the first differing bit.
module serial_mag_comp
  import serial_mag_comp_pkg::*;
#(
  parameter int N          = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_mag_comp_if.slave   bus
);
  localparam int IW = $clog2(N);

  state_t        r_state, w_nstate;
  logic [N-1:0]  r_a, r_b;
  logic [IW-1:0] r_idx;
  logic          r_dec;
  logic [2:0]    r_res;
  logic [2:0]    r_gel;

  logic          w_g, w_e, w_l;
  logic [2:0]    w_gel;
  logic          w_last, w_diff, w_fin, w_accept;

  comp_1bit_gel u_cell (
    .i_a (r_a[r_idx]),
    .i_b (r_b[r_idx]),
    .o_g (w_g),
    .o_e (w_e),
    .o_l (w_l)
  );

  assign w_gel    = gel_pack(w_g, w_e, w_l);
  assign w_diff   = ~w_e;
  assign w_last   = (r_idx == '0);
  assign w_accept = bus.start && (r_state != ST_RUN);
  assign w_fin    = (r_state == ST_RUN) && (w_last || (EARLY_EXIT && w_diff));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_nstate;
  end

  always_comb begin
    w_nstate = r_state;
    case (r_state)
      ST_IDLE: if (bus.start) w_nstate = ST_RUN;
      ST_RUN:  if (w_fin)     w_nstate = ST_DONE;
      ST_DONE: w_nstate = bus.start ? ST_RUN : ST_IDLE;
      default: w_nstate = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (r_state == ST_RUN);
    bus.done = (r_state == ST_DONE);
    {bus.g, bus.e, bus.l} = r_gel;
  end

  // r_res holds the first difference so later bits cannot override it in
  // constant-time mode; r_gel only changes on the deciding edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_idx <= IW'(N-1);
      r_dec <= 1'b0;
      r_res <= GEL_EQ;
      r_gel <= GEL_EQ;
    end else if (w_accept) begin
      r_a   <= bus.a;
      r_b   <= bus.b;
      r_idx <= IW'(N-1);
      r_dec <= 1'b0;
    end else if (r_state == ST_RUN) begin
      if (w_diff && !r_dec) begin
        r_dec <= 1'b1;
        r_res <= w_gel;
      end
      if (w_fin) r_gel <= r_dec ? r_res : w_gel;
      else       r_idx <= r_idx - IW'(1);
    end
  end
endmodule

// File: tb/tb_serial_mag_comp.sv
// Runs an early-exit and a constant-time comparator side by side against a
// per-instance transaction model (latency from the first differing bit).
module tb_serial_mag_comp;
  localparam int NB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_mag_comp_if #(.N(NB)) if0 ();
  serial_mag_comp_if #(.N(NB)) if1 ();

  serial_mag_comp #(.N(NB), .EARLY_EXIT(1'b1)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  serial_mag_comp #(.N(NB), .EARLY_EXIT(1'b0)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  logic          st [2];
  logic [NB-1:0] sa [2];
  logic [NB-1:0] sb [2];
  logic          ob_busy [2];
  logic          ob_done [2];
  logic [2:0]    ob_gel  [2];

  assign if0.start = st[0];
  assign if0.a     = sa[0];
  assign if0.b     = sb[0];
  assign if1.start = st[1];
  assign if1.a     = sa[1];
  assign if1.b     = sb[1];
  assign ob_busy[0] = if0.busy;
  assign ob_done[0] = if0.done;
  assign ob_gel[0]  = {if0.g, if0.e, if0.l};
  assign ob_busy[1] = if1.busy;
  assign ob_done[1] = if1.done;
  assign ob_gel[1]  = {if1.g, if1.e, if1.l};

  int         n_chk = 0;
  int         n_err = 0;
  bit         ee    [2] = '{1'b1, 1'b0};
  int         m_cnt [2] = '{0, 0};
  logic       m_done[2] = '{1'b0, 1'b0};
  logic [2:0] m_gel [2] = '{3'b010, 3'b010};
  logic [2:0] m_pend[2] = '{3'b010, 3'b010};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [2:0] ref_gel(input logic [NB-1:0] x, input logic [NB-1:0] y);
    if (x > y)       return 3'b100;
    else if (x == y) return 3'b010;
    else             return 3'b001;
  endfunction

  // Bits examined: through the most significant differing bit, or all of them.
  function automatic int bits_examined(input logic [NB-1:0] x, input logic [NB-1:0] y, input bit early);
    logic [NB-1:0] d;
    int p;
    if (!early || x == y) return NB;
    d = x ^ y;
    p = 0;
    for (int i = 0; i < NB; i++) if (d[i]) p = i;
    return NB - p;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_cnt[d] = 0; m_done[d] = 1'b0; m_gel[d] = 3'b010;
    end
  endtask

  task automatic check_all(input string ph);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s_busy%0d", ph, d), ob_busy[d], m_cnt[d] > 0);
      chk($sformatf("%s_done%0d", ph, d), ob_done[d], m_done[d]);
      chk($sformatf("%s_gel%0d",  ph, d), ob_gel[d],  m_gel[d]);
      chk($sformatf("%s_onehot%0d", ph, d), $countones(ob_gel[d]), 1);
    end
  endtask

  task automatic step(input string ph);
    @(posedge clk);
    if (!rst_n) model_reset();
    else begin
      for (int d = 0; d < 2; d++) begin
        logic nd;
        nd = 1'b0;
        if (m_cnt[d] > 0) begin
          m_cnt[d]--;
          if (m_cnt[d] == 0) begin nd = 1'b1; m_gel[d] = m_pend[d]; end
        end else if (st[d]) begin
          m_cnt[d]  = bits_examined(sa[d], sb[d], ee[d]);
          m_pend[d] = ref_gel(sa[d], sb[d]);
        end
        m_done[d] = nd;
      end
    end
    @(negedge clk);
    check_all(ph);
  endtask

  function automatic bit both_idle();
    return (m_cnt[0] == 0) && (m_cnt[1] == 0) && !m_done[0] && !m_done[1];
  endfunction

  task automatic go(input string ph, input logic [NB-1:0] va, input logic [NB-1:0] vb,
                    output int bc0, output int bc1);
    st = '{1'b1, 1'b1}; sa = '{va, va}; sb = '{vb, vb};
    step(ph);
    st = '{1'b0, 1'b0};
    bc0 = 0; bc1 = 0;
    for (int i = 0; i < 20; i++) begin
      if (ob_busy[0]) bc0++;
      if (ob_busy[1]) bc1++;
      if (both_idle()) break;
      for (int d = 0; d < 2; d++) begin
        sa[d] = 4'($urandom);
        sb[d] = 4'($urandom);
      end
      step(ph);
    end
  endtask

  initial begin
    int c0, c1;
    bit used [2];
    st = '{1'b0, 1'b0}; sa = '{4'h0, 4'h0}; sb = '{4'h0, 4'h0};
    repeat (2) @(negedge clk);
    check_all("rst");
    rst_n = 1'b1;
    step("rst_rel");

    go("gt", 4'b1010, 4'b0111, c0, c1);
    chk("gt_gel0", ob_gel[0], 3'b100);
    chk("gt_gel1", ob_gel[1], 3'b100);
    chk("gt_busy0", c0, 1);
    chk("gt_busy1", c1, 4);

    go("lt", 4'b0110, 4'b0111, c0, c1);
    chk("lt_gel0", ob_gel[0], 3'b001);
    chk("lt_busy0", c0, 4);

    go("eq", 4'b1001, 4'b1001, c0, c1);
    chk("eq_gel0", ob_gel[0], 3'b010);
    chk("eq_gel1", ob_gel[1], 3'b010);
    chk("eq_busy0", c0, 4);

    go("sticky", 4'b1000, 4'b0111, c0, c1);
    chk("sticky_gel1", ob_gel[1], 3'b100);
    chk("sticky_busy1", c1, 4);

    // Abort a run with reset: outputs drop at once, no done follows.
    st = '{1'b1, 1'b1}; sa = '{4'b0110, 4'b0110}; sb = '{4'b0111, 4'b0111};
    step("abort_st");
    st = '{1'b0, 1'b0};
    step("abort_run");
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("abort_rst");
    repeat (2) step("abort_hold");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) step("abort_after");

    // Junk starts while busy are ignored; a start in the DONE cycle is taken.
    used = '{1'b0, 1'b0};
    st = '{1'b1, 1'b1}; sa = '{4'b0110, 4'b0110}; sb = '{4'b0111, 4'b0111};
    step("b2b_st");
    for (int i = 0; i < 40; i++) begin
      for (int d = 0; d < 2; d++) begin
        if (m_cnt[d] > 0) begin
          st[d] = 1'($urandom); sa[d] = 4'($urandom); sb[d] = 4'($urandom);
        end else if (m_done[d] && !used[d]) begin
          st[d] = 1'b1; sa[d] = 4'b0001; sb[d] = 4'b0010; used[d] = 1'b1;
        end else st[d] = 1'b0;
      end
      if (used[0] && used[1] && both_idle()) break;
      step("b2b");
    end
    chk("b2b_gel0", ob_gel[0], 3'b001);
    chk("b2b_gel1", ob_gel[1], 3'b001);
    chk("b2b_used", {30'd0, used[1], used[0]}, 32'd3);

    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++) begin
        go("sweep", 4'(x), 4'(y), c0, c1);
        chk("sweep_res0", ob_gel[0], ref_gel(4'(x), 4'(y)));
        chk("sweep_res1", ob_gel[1], ref_gel(4'(x), 4'(y)));
      end

    for (int i = 0; i < 400; i++) begin
      for (int d = 0; d < 2; d++) begin
        st[d] = ($urandom_range(0, 2) == 0);
        sa[d] = 4'($urandom);
        sb[d] = 4'($urandom);
      end
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
